// File: rtl/branch_cmp_unit.sv
// branch_cmp_unit: ID-stage branch condition resolver with a per-PC 2-bit
// saturating predictor table, a registered mispredict pulse and taken/executed
// branch performance counters.
module branch_cmp_unit #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 6,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [2:0]       op,
  input  logic             b,
  input  logic             stall,
  input  logic [IDX_W-1:0] pc_idx,
  output logic             branch,
  output logic             predict,
  output logic             mispredict,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] branch_cnt
);

  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [2:0] {
    OP_BEQ  = 3'd0,
    OP_BNE  = 3'd1,
    OP_BLEZ = 3'd2,
    OP_BGTZ = 3'd3,
    OP_BLTZ = 3'd4,
    OP_BGEZ = 3'd5,
    OP_BLT  = 3'd6,
    OP_BLTU = 3'd7
  } cmp_op_e;

  logic       cond;
  logic       resolve;
  logic       sign;
  logic       zero;
  logic [1:0] cur;
  logic [1:0] pht [DEPTH];

  assign sign    = i1[WIDTH-1];
  assign zero    = (i1 == '0);
  assign resolve = b & ~stall;
  assign cur     = pht[pc_idx];
  assign predict = cur[1];
  assign branch  = b & cond;

  // Evaluate the selected branch condition; unknown encodings resolve not-taken
  always_comb begin
    cond = 1'b0;
    case (cmp_op_e'(op))
      OP_BEQ:  cond = (i1 == i2);
      OP_BNE:  cond = (i1 != i2);
      OP_BLEZ: cond = sign | zero;
      OP_BGTZ: cond = ~sign & ~zero;
      OP_BLTZ: cond = sign;
      OP_BGEZ: cond = ~sign;
      OP_BLT:  cond = ($signed(i1) < $signed(i2));
      OP_BLTU: cond = (i1 < i2);
      default: cond = 1'b0;
    endcase
  end

  // Train the indexed saturating counter on each resolved branch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pht[i] <= 2'b01;
      end
    end else if (resolve) begin
      if (cond) begin
        if (cur != 2'b11) pht[pc_idx] <= cur + 2'b01;
      end else begin
        if (cur != 2'b00) pht[pc_idx] <= cur - 2'b01;
      end
    end
  end

  // Flag a disagreement between the pre-update prediction and the outcome
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mispredict <= 1'b0;
    end else begin
      mispredict <= resolve & (cur[1] != cond);
    end
  end

  // Count resolved and taken branches, wrapping at the counter width
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else if (resolve) begin
      branch_cnt <= branch_cnt + CNT_W'(1);
      taken_cnt  <= taken_cnt + CNT_W'(cond);
    end
  end

endmodule
